// File: rtl/chip_boot_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : chip_boot_sequencer                                          |
// | Description : Boot/run sequencer for N_CHAN chip instances run side by     |
// |               side. Holds the chips in reset, optionally waits for an SPI  |
// |               preload, raises fetch-enable after a programmable delay,     |
// |               then captures each chip's EOC/pass result. It flags pass     |
// |               disagreement between chips and enforces a run timeout.       |
// | Ports       : clk, rst (sync, active-high)                                 |
// |               start_i / abort_i       sequence control pulses              |
// |               chan_en_i               channels taking part (sampled on     |
// |                                       an accepted start)                   |
// |               load_done_i             SPI preload finished (level)         |
// |               eoc_i / pass_i          per-chip end-of-computation / pass   |
// |               chip_rst_n_o/fetch_en_o per-chip pad drives                  |
// |               busy_o, chan_done_o, chan_pass_o, mismatch_o, timeout_o,     |
// |               cycles_o                status                               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module chip_boot_sequencer #(
  parameter int N_CHAN     = 2,
  parameter int RST_CYCLES = 16,
  parameter int FE_DELAY   = 4,
  parameter int PRELOAD    = 1,
  parameter int TIMEOUT    = 100000,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [N_CHAN-1:0] chan_en_i,
  input  logic              load_done_i,
  input  logic [N_CHAN-1:0] eoc_i,
  input  logic [N_CHAN-1:0] pass_i,
  output logic [N_CHAN-1:0] chip_rst_n_o,
  output logic [N_CHAN-1:0] fetch_en_o,
  output logic              busy_o,
  output logic [N_CHAN-1:0] chan_done_o,
  output logic [N_CHAN-1:0] chan_pass_o,
  output logic              mismatch_o,
  output logic              timeout_o,
  output logic [CNT_W-1:0]  cycles_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RESET = 3'd1,
    S_LOAD  = 3'd2,
    S_DELAY = 3'd3,
    S_RUN   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam int               PH_W        = 32;
  // A zero reset length still needs one cycle of reset on the pads.
  localparam int               RST_LEN     = (RST_CYCLES < 1) ? 1 : RST_CYCLES;
  localparam logic [PH_W-1:0]  c_rst_last  = PH_W'(RST_LEN - 1);
  localparam logic [PH_W-1:0]  c_fe_last   = (FE_DELAY < 1) ? '0 : PH_W'(FE_DELAY - 1);
  localparam logic [CNT_W-1:0] c_to_last   = (TIMEOUT < 1) ? '0 : CNT_W'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [N_CHAN-1:0]   en_q, en_d;
  logic [N_CHAN-1:0]   done_q, done_d;
  logic [N_CHAN-1:0]   pass_q, pass_d;
  logic                timeout_q, timeout_d;
  logic                mismatch_q, mismatch_d;
  logic [CNT_W-1:0]    cycles_q, cycles_d;
  logic [N_CHAN-1:0]   chip_rst_n_q, chip_rst_n_d;
  logic [N_CHAN-1:0]   fetch_en_q, fetch_en_d;
  logic                busy_q, busy_d;

  logic                w_start_ok;
  logic [N_CHAN-1:0]   w_new_cap;
  state_t              w_after_load;
  state_t              w_after_rst;

  assign w_start_ok = start_i && (chan_en_i != '0);
  // Only the first EOC of an enabled channel is captured.
  assign w_new_cap  = en_q & eoc_i & ~done_q;

  always_comb begin
    w_after_load = (FE_DELAY > 0) ? S_DELAY : S_RUN;
    w_after_rst  = (PRELOAD != 0) ? S_LOAD : w_after_load;

    state_d    = state_q;
    phase_d    = phase_q;
    en_d       = en_q;
    done_d     = done_q;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    mismatch_d = mismatch_q;
    cycles_d   = cycles_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (w_start_ok) begin
          state_d    = S_RESET;
          phase_d    = '0;
          en_d       = chan_en_i;
          done_d     = '0;
          pass_d     = '0;
          timeout_d  = 1'b0;
          mismatch_d = 1'b0;
          cycles_d   = '0;
        end
      end
      S_RESET: begin
        if (phase_q == c_rst_last) begin
          phase_d = '0;
          state_d = w_after_rst;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_LOAD: begin
        if (load_done_i) begin
          phase_d = '0;
          state_d = w_after_load;
        end
      end
      S_DELAY: begin
        if (phase_q == c_fe_last) begin
          phase_d = '0;
          state_d = S_RUN;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_RUN: begin
        cycles_d = cycles_q + 1'b1;
        done_d   = done_q | w_new_cap;
        pass_d   = (pass_q & ~w_new_cap) | (pass_i & w_new_cap);
        // Captures on this cycle count before the timeout is judged.
        if ((done_d & en_q) == en_q) begin
          state_d   = S_DONE;
          timeout_d = 1'b0;
        end else if (cycles_d >= c_to_last) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end
        if (state_d == S_DONE) begin
          mismatch_d = (|(done_d & en_q & pass_d)) && (|(done_d & en_q & ~pass_d));
        end
      end
      default: begin
        state_d = S_IDLE;
        phase_d = '0;
      end
    endcase

    // Abort overrides everything and leaves the status untouched.
    if (abort_i) begin
      state_d    = S_IDLE;
      phase_d    = '0;
      en_d       = en_q;
      done_d     = done_q;
      pass_d     = pass_q;
      timeout_d  = timeout_q;
      mismatch_d = mismatch_q;
      cycles_d   = cycles_q;
    end

    // Pad drives and busy follow the state being entered so they are registered.
    chip_rst_n_d = (state_d inside {S_LOAD, S_DELAY, S_RUN, S_DONE}) ? en_d : '0;
    fetch_en_d   = (state_d == S_RUN) ? en_d : '0;
    busy_d       = state_d inside {S_RESET, S_LOAD, S_DELAY, S_RUN};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      phase_q      <= '0;
      en_q         <= '0;
      done_q       <= '0;
      pass_q       <= '0;
      timeout_q    <= 1'b0;
      mismatch_q   <= 1'b0;
      cycles_q     <= '0;
      chip_rst_n_q <= '0;
      fetch_en_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      en_q         <= en_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
      mismatch_q   <= mismatch_d;
      cycles_q     <= cycles_d;
      chip_rst_n_q <= chip_rst_n_d;
      fetch_en_q   <= fetch_en_d;
      busy_q       <= busy_d;
    end
  end

  assign chip_rst_n_o = chip_rst_n_q;
  assign fetch_en_o   = fetch_en_q;
  assign busy_o       = busy_q;
  assign chan_done_o  = done_q;
  assign chan_pass_o  = pass_q;
  assign mismatch_o   = mismatch_q;
  assign timeout_o    = timeout_q;
  assign cycles_o     = cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_chip_boot_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_chip_boot_sequencer                                       |
// | Description : Self-checking bench for chip_boot_sequencer. Instance A has  |
// |               no preload phase, instance B waits for load_done_i. A       |
// |               phase/timeline model predicts every output each cycle, and  |
// |               directed hand-computed values pin the model.                |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_chip_boot_sequencer;

  localparam int RSTC = 16;
  localparam int FED  = 4;
  localparam int TO   = 1000;

  localparam int P_IDLE  = 0;
  localparam int P_RESET = 1;
  localparam int P_LOAD  = 2;
  localparam int P_DELAY = 3;
  localparam int P_RUN   = 4;
  localparam int P_DONE  = 5;

  typedef struct packed {
    int         ph;
    int         left;
    int         runs;
    logic [1:0] en;
    logic [1:0] done;
    logic [1:0] pass;
    logic       tmo;
    logic       mism;
  } mdl_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_s [2];
  logic        abort_s [2];
  logic        load_s  [2];
  logic [1:0]  en_s    [2];
  logic [1:0]  eoc_s   [2];
  logic [1:0]  pass_s  [2];
  wire  [1:0]  rstn_s  [2];
  wire  [1:0]  fe_s    [2];
  wire  [1:0]  done_s  [2];
  wire  [1:0]  cpass_s [2];
  wire         busy_s  [2];
  wire         mism_s  [2];
  wire         tmo_s   [2];
  wire  [31:0] cyc_s   [2];

  mdl_t m [2];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  bit   chk_on = 1'b0;
  int   t      = 0;

  always #5 clk = ~clk;

  chip_boot_sequencer #(
    .N_CHAN(2), .RST_CYCLES(RSTC), .FE_DELAY(FED), .PRELOAD(0), .TIMEOUT(TO), .CNT_W(32)
  ) u_dut_a (
    .clk(clk), .rst(rst), .start_i(start_s[0]), .abort_i(abort_s[0]),
    .chan_en_i(en_s[0]), .load_done_i(load_s[0]), .eoc_i(eoc_s[0]), .pass_i(pass_s[0]),
    .chip_rst_n_o(rstn_s[0]), .fetch_en_o(fe_s[0]), .busy_o(busy_s[0]),
    .chan_done_o(done_s[0]), .chan_pass_o(cpass_s[0]), .mismatch_o(mism_s[0]),
    .timeout_o(tmo_s[0]), .cycles_o(cyc_s[0])
  );

  chip_boot_sequencer #(
    .N_CHAN(2), .RST_CYCLES(RSTC), .FE_DELAY(FED), .PRELOAD(1), .TIMEOUT(TO), .CNT_W(32)
  ) u_dut_b (
    .clk(clk), .rst(rst), .start_i(start_s[1]), .abort_i(abort_s[1]),
    .chan_en_i(en_s[1]), .load_done_i(load_s[1]), .eoc_i(eoc_s[1]), .pass_i(pass_s[1]),
    .chip_rst_n_o(rstn_s[1]), .fetch_en_o(fe_s[1]), .busy_o(busy_s[1]),
    .chan_done_o(done_s[1]), .chan_pass_o(cpass_s[1]), .mismatch_o(mism_s[1]),
    .timeout_o(tmo_s[1]), .cycles_o(cyc_s[1])
  );

  // ---------------------------------------------------------------- model
  function automatic mdl_t enter_fe(mdl_t c);
    mdl_t n = c;
    if (FED > 0) begin
      n.ph   = P_DELAY;
      n.left = FED;
    end else begin
      n.ph = P_RUN;
    end
    return n;
  endfunction

  function automatic mdl_t step(mdl_t c, bit pre, logic st, logic ab, logic [1:0] en,
                                logic ld, logic [1:0] eoc, logic [1:0] ps);
    mdl_t n = c;
    int   n1 = 0;
    int   n0 = 0;
    if (ab) begin
      n.ph = P_IDLE;
      return n;
    end
    case (c.ph)
      P_IDLE, P_DONE: begin
        if (st && en != 2'b00) begin
          n      = '0;
          n.ph   = P_RESET;
          n.left = (RSTC > 0) ? RSTC : 1;
          n.en   = en;
        end
      end
      P_RESET: begin
        if (c.left == 1) begin
          if (pre) n.ph = P_LOAD;
          else     n = enter_fe(n);
        end else begin
          n.left = c.left - 1;
        end
      end
      P_LOAD: if (ld) n = enter_fe(n);
      P_DELAY: begin
        if (c.left == 1) n.ph = P_RUN;
        else             n.left = c.left - 1;
      end
      P_RUN: begin
        n.runs = c.runs + 1;
        for (int i = 0; i < 2; i++) begin
          if (c.en[i] && eoc[i] && !c.done[i]) begin
            n.done[i] = 1'b1;
            n.pass[i] = ps[i];
          end
        end
        if ((n.done & n.en) == n.en) begin
          n.ph  = P_DONE;
          n.tmo = 1'b0;
        end else if (n.runs >= TO - 1) begin
          n.ph  = P_DONE;
          n.tmo = 1'b1;
        end
        if (n.ph == P_DONE) begin
          for (int i = 0; i < 2; i++) begin
            if (n.en[i] && n.done[i]) begin
              if (n.pass[i]) n1++;
              else           n0++;
            end
          end
          n.mism = (n1 > 0) && (n0 > 0);
        end
      end
      default: n.ph = P_IDLE;
    endcase
    return n;
  endfunction

  function automatic logic [1:0] exp_rstn(mdl_t c);
    return (c.ph >= P_LOAD) ? c.en : 2'b00;
  endfunction

  function automatic logic [1:0] exp_fe(mdl_t c);
    return (c.ph == P_RUN) ? c.en : 2'b00;
  endfunction

  function automatic logic exp_busy(mdl_t c);
    return (c.ph >= P_RESET) && (c.ph <= P_RUN);
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) m[d] <= '0;
      else     m[d] <= step(m[d], d == 1, start_s[d], abort_s[d], en_s[d],
                            load_s[d], eoc_s[d], pass_s[d]);
    end
    if (rst) chk_on <= 1'b1;
  end

  // ---------------------------------------------------------------- checking
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30)
        $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("rstn[%0d]", d),  32'(rstn_s[d]),  32'(exp_rstn(m[d])));
        chk($sformatf("fe[%0d]", d),    32'(fe_s[d]),    32'(exp_fe(m[d])));
        chk($sformatf("busy[%0d]", d),  32'(busy_s[d]),  32'(exp_busy(m[d])));
        chk($sformatf("done[%0d]", d),  32'(done_s[d]),  32'(m[d].done));
        chk($sformatf("pass[%0d]", d),  32'(cpass_s[d]), 32'(m[d].pass));
        chk($sformatf("mism[%0d]", d),  32'(mism_s[d]),  32'(m[d].mism));
        chk($sformatf("tmo[%0d]", d),   32'(tmo_s[d]),   32'(m[d].tmo));
        chk($sformatf("cyc[%0d]", d),   cyc_s[d],        32'(m[d].runs));
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic tick();
    @(negedge clk);
    t++;
  endtask

  task automatic to(input int k);
    while (t < k) tick();
  endtask

  // Raises start on instance d; the cycle it is sampled in is cycle 0.
  task automatic begin_seq(input int d, input logic [1:0] en);
    start_s[d] = 1'b1;
    en_s[d]    = en;
    t          = 0;
    tick();
    start_s[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0;
      abort_s[d] = 1'b0;
      load_s[d]  = 1'b0;
      en_s[d]    = 2'b00;
      eoc_s[d]   = 2'b00;
      pass_s[d]  = 2'b00;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_rstn", 32'(rstn_s[0]), 32'h0);
    chk("reset_busy", 32'(busy_s[0]), 32'h0);
    chk("reset_cyc",  cyc_s[0],       32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic boot: reset release at 17, fetch enable at 21, both pass.
    begin_seq(0, 2'b11);
    to(16); chk("t1_rstn_c16", 32'(rstn_s[0]), 32'h0);
    to(17); chk("t1_rstn_c17", 32'(rstn_s[0]), 32'h3);
            chk("t1_fe_c17",   32'(fe_s[0]),   32'h0);
    to(20); chk("t1_fe_c20",   32'(fe_s[0]),   32'h0);
    to(21); chk("t1_fe_c21",   32'(fe_s[0]),   32'h3);
    to(26); eoc_s[0] = 2'b11; pass_s[0] = 2'b11;
    to(27); chk("t1_pass", 32'(cpass_s[0]), 32'h3);
            chk("t1_mism", 32'(mism_s[0]),  32'h0);
            chk("t1_cyc",  cyc_s[0],        32'd6);
    eoc_s[0] = 2'b00; pass_s[0] = 2'b00;
    to(30);

    // Disagreeing results: ch0 passes at RUN 100, ch1 fails at RUN 200.
    begin_seq(0, 2'b11);
    to(121); eoc_s[0] = 2'b01; pass_s[0] = 2'b01;
    to(221); eoc_s[0] = 2'b11;
    to(222); chk("t3_pass", 32'(cpass_s[0]), 32'h1);
             chk("t3_mism", 32'(mism_s[0]),  32'h1);
             chk("t3_cyc",  cyc_s[0],        32'd201);
    eoc_s[0] = 2'b00; pass_s[0] = 2'b00;
    to(225);

    // Timeout with ch1 silent.
    begin_seq(0, 2'b11);
    to(31);   eoc_s[0] = 2'b01; pass_s[0] = 2'b01;
    to(1019); chk("t4a_busy", 32'(busy_s[0]), 32'h1);
    to(1020); chk("t4a_tmo",  32'(tmo_s[0]),  32'h1);
              chk("t4a_done", 32'(done_s[0]), 32'h1);
              chk("t4a_cyc",  cyc_s[0],       32'd999);
    eoc_s[0] = 2'b00; pass_s[0] = 2'b00;
    to(1023);

    // ch1 EOC lands on the timeout cycle: capture wins.
    begin_seq(0, 2'b11);
    to(31);   eoc_s[0] = 2'b01; pass_s[0] = 2'b01;
    to(1019); eoc_s[0] = 2'b11;
    to(1020); chk("t4b_tmo",  32'(tmo_s[0]),  32'h0);
              chk("t4b_done", 32'(done_s[0]), 32'h3);
              chk("t4b_cyc",  cyc_s[0],       32'd999);
    eoc_s[0] = 2'b00; pass_s[0] = 2'b00;
    to(1023);

    // Start pulse mid-run ignored, then abort in RUN.
    begin_seq(0, 2'b11);
    to(23); start_s[0] = 1'b1; en_s[0] = 2'b01;
    to(24); start_s[0] = 1'b0; en_s[0] = 2'b11;
            chk("t6_fe_run",  32'(fe_s[0]), 32'h3);
            chk("t6_cyc_run", cyc_s[0],     32'd3);
    to(26); abort_s[0] = 1'b1;
    to(27); abort_s[0] = 1'b0;
            chk("t6_abort_rstn", 32'(rstn_s[0]), 32'h0);
            chk("t6_abort_fe",   32'(fe_s[0]),   32'h0);
            chk("t6_abort_busy", 32'(busy_s[0]), 32'h0);
    // Start with no channels enabled stays idle.
    start_s[0] = 1'b1; en_s[0] = 2'b00;
    tick(); start_s[0] = 1'b0;
    tick(); chk("t5_en0_busy", 32'(busy_s[0]), 32'h0);

    // Synchronous reset while in DELAY.
    begin_seq(0, 2'b11);
    to(18); rst = 1'b1;
    to(19); rst = 1'b0;
            chk("t6_rst_rstn", 32'(rstn_s[0]), 32'h0);
            chk("t6_rst_busy", 32'(busy_s[0]), 32'h0);
    to(22);

    // Only ch0 enabled; ch1 inputs toggle and must be ignored.
    begin_seq(0, 2'b01);
    for (int k = 2; k <= 30; k++) begin
      to(k);
      eoc_s[0][1]  = k[0];
      pass_s[0][1] = ~k[0];
      if (k == 24) begin
        eoc_s[0][0]  = 1'b1;
        pass_s[0][0] = 1'b1;
      end
      if (k == 20) chk("t5_rstn_c20", 32'(rstn_s[0]), 32'h1);
    end
    chk("t5_done", 32'(done_s[0]),  32'h1);
    chk("t5_pass", 32'(cpass_s[0]), 32'h1);
    chk("t5_cyc",  cyc_s[0],        32'd4);
    eoc_s[0] = 2'b00; pass_s[0] = 2'b00;
    to(32);

    // Preload instance: LOAD from cycle 17, load_done at 67, fetch enable at 72.
    begin_seq(1, 2'b11);
    to(40); chk("t2_rstn_load", 32'(rstn_s[1]), 32'h3);
            chk("t2_fe_load",   32'(fe_s[1]),   32'h0);
    to(67); load_s[1] = 1'b1;
    to(71); chk("t2_fe_c71", 32'(fe_s[1]), 32'h0);
    to(72); chk("t2_fe_c72", 32'(fe_s[1]), 32'h3);
    to(80); eoc_s[1] = 2'b11; pass_s[1] = 2'b11;
    to(81); chk("t2_pass", 32'(cpass_s[1]), 32'h3);
            chk("t2_cyc",  cyc_s[1],        32'd9);
    eoc_s[1] = 2'b00; pass_s[1] = 2'b00; load_s[1] = 1'b0;
    to(84);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
